uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmit line between NREQ byte requesters. It arbitrates pending requests round-robin, latches the winner's byte, and serialises it as 8N1 (start bit, 8 data bits LSB first, stop bit) using its own bit-period counter. It sits between on-chip byte producers and the FPGA TX pin, alongside the standalone baud generator.

## Interface
- CLOCK_FREQ, 12000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s. BIT_CYCLES = CLOCK_FREQ / BAUD (integer division) must be ≥ 2.
- NREQ, 4, number of requesters, legal range 2..8. IDW = clog2(NREQ), with a minimum of 1.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  NREQ  per-requester "byte pending". Hold it with the data until granted.
- data  input  8*NREQ  byte for requester i on data[8i+7:8i].
- grant  output  NREQ  one-hot, one-cycle pulse: requester i's byte has been accepted.
- busy  output  1  high while a frame is on the line.
- active_id  output  IDW  index of the requester whose frame is on the line (last winner when idle).
- tx  output  1  serial line, idle high.

## Operation
- **States:** IDLE, START, DATA, STOP.
- **Registers:** bit timer (0..BIT_CYCLES-1), bit index (0..7), 8-bit shift register, round-robin pointer `last` (IDW bits).
- **Reset values (asynchronous):**
  - state = IDLE; tx = 1; busy = 0; grant = 0; active_id = 0.
  - last = NREQ-1, so requester 0 has top priority after reset.
  - timer and bit index = 0.
- **Arbitration** is evaluated only in IDLE and on the final cycle of STOP.
  - Winner = first i with req[i]=1, searching last+1, last+2, … modulo NREQ.
  - On a win:
    - grant[winner] is pulsed for one cycle.
    - data of the winner is loaded into the shift register.
    - active_id and last are set to the winner.
    - busy goes to 1, tx goes to 0, timer = 0, state = START.
- **START:** tx = 0 for BIT_CYCLES cycles, then go to DATA with tx = shift[0].
- **DATA:** each bit is held for BIT_CYCLES cycles, then the register shifts right and the bit index increments. After bit 7 completes, go to STOP with tx = 1.
- **STOP:** tx = 1 for BIT_CYCLES cycles.
  - On the last cycle, if any req is high: arbitrate as above and go straight to START. There is no idle gap and busy stays 1.
  - Otherwise: go to IDLE and set busy = 0.
- **req handling:**
  - req is ignored outside the arbitration points.
  - A req deasserted before its grant is simply not served. Withdrawal is legal.
  - data is sampled only in the grant cycle. Changes at any other time have no effect.
- **Round-robin guarantee:** a continuously requesting requester waits at most NREQ-1 frames.

## Timing
- **Grant latency:** req sampled high at edge k in IDLE → grant, busy = 1 and tx = 0 are all visible after edge k, i.e. 1 cycle.
- **Frame length:** exactly 10 × BIT_CYCLES cycles, measured from the first tx = 0 cycle to the first cycle after the stop bit.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the previous stop bit's last cycle. The next grant pulse lands in that same first cycle of the start bit.
- **Bit timing:** each bit boundary is exact to the cycle. The timer restarts at every frame, with no accumulated drift.
- **grant:** never high in two consecutive cycles, and never multi-hot.
- **Reset mid-frame:**
  - tx = 1 and busy = 0 immediately, without waiting for a clock edge.
  - The frame is abandoned.
  - After release, arbitration restarts from requester 0.
- **Simultaneous events:** a req rising on the last STOP cycle is eligible in that same arbitration.

## Test plan
All tests use CLOCK_FREQ = 16, BAUD = 1 (BIT_CYCLES = 16) and NREQ = 4.
- **Reset state:** assert rst mid-sim with req = 4'b1111 → tx = 1, busy = 0, grant = 0 and active_id = 0 while rst is high. After release, the first grant is 4'b0001.
- **Single byte:** req[0] = 1 with data byte 0xA5 →
  - one grant = 4'b0001 pulse;
  - tx carries 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles;
  - busy is high for 160 cycles, then returns to 0 with tx = 1.
- **All requesters held high** (bytes 0x11, 0x22, 0x33, 0x44) →
  - grant order 0,1,2,3,0;
  - grants spaced exactly 160 cycles apart;
  - busy never drops;
  - decoded bytes match.
- **Fairness:** req[0] and req[2] held → grants alternate 0,2,0,2 and active_id tracks them.
- **Withdraw:** req[1] pulsed high and then low during another requester's frame, before that frame's final STOP cycle → no grant[1] and no extra frame.
- **Reset mid-frame:** rst asserted at cycle 70 of a frame → tx = 1 in the same cycle. After release with req[3] = 1, a clean full frame for requester 3 is sent.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX line between NREQ byte producers. Pending requests are
//   arbitrated round-robin. The winner's byte is latched and sent as 8N1
//   (start, 8 data bits LSB first, stop). The bit timing comes from an
//   internal bit-period counter.
//
// Parameters
//   CLOCK_FREQ  system clock frequency in Hz
//   BAUD        line rate in bit/s (CLOCK_FREQ / BAUD must be >= 2)
//   NREQ        number of requesters, 2..8
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-requester "byte pending", held with data until granted
//   data       byte for requester i on data[8i+7:8i]
//   grant      one-hot single-cycle pulse: requester's byte was accepted
//   busy       high while a frame is on the line
//   active_id  requester whose frame is on the line (last winner when idle)
//   tx         serial output, idle high
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | line idle (tx = 1), arbitrating every cycle
// START | start bit (tx = 0) for one bit period
// DATA  | data bits 0..7, LSB first, one bit period each
// STOP  | stop bit (tx = 1); re-arbitrates on its final cycle

module uart_tx_arbiter #(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD       = 9600,
    parameter int NREQ       = 4,
    localparam int IDW       = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [IDW-1:0]    active_id,
    output logic              tx
);

    localparam int BIT_CYCLES = CLOCK_FREQ / BAUD;
    localparam int TW         = $clog2(BIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shift, shift_n;
    logic [IDW-1:0]  last, last_n;
    logic [IDW-1:0]  active_id_n;
    logic [NREQ-1:0] grant_n;
    logic            busy_n;
    logic            tx_n;

    logic            win_found;
    logic [IDW-1:0]  win_id;
    logic [7:0]      win_byte;
    logic            bit_end;
    logic            arb;

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!win_found && req[(int'(last) + k) % NREQ]) begin
                win_found = 1'b1;
                win_id    = IDW'((int'(last) + k) % NREQ);
            end
        end
    end

    always_comb begin
        win_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == IDW'(i)) begin
                win_byte = data[8*i +: 8];
            end
        end
    end

    assign bit_end = (timer == TW'(BIT_CYCLES - 1));

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        last_n      = last;
        active_id_n = active_id;
        grant_n     = '0;
        busy_n      = busy;
        tx_n        = tx;
        arb         = 1'b0;

        case (state)
            IDLE: begin
                arb = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    tx_n      = shift[0];
                    state_n   = DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_n = '0;
                    if (bit_idx == 3'd7) begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = shift >> 1;
                        tx_n      = shift[1];
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    // Default to going idle; a winner below overrides this
                    // so back-to-back frames have no gap.
                    arb     = 1'b1;
                    timer_n = '0;
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (arb && win_found) begin
            grant_n     = NREQ'(1) << win_id;
            shift_n     = win_byte;
            active_id_n = win_id;
            last_n      = win_id;
            busy_n      = 1'b1;
            tx_n        = 1'b0;
            timer_n     = '0;
            bit_idx_n   = '0;
            state_n     = START;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            last      <= IDW'(NREQ - 1);
            active_id <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            tx        <= 1'b1;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            bit_idx   <= bit_idx_n;
            shift     <= shift_n;
            last      <= last_n;
            active_id <= active_id_n;
            grant     <= grant_n;
            busy      <= busy_n;
            tx        <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with BIT_CYCLES = 16 and NREQ = 4.
// A frame-level reference model predicts tx/busy/grant/active_id on every
// cycle. Table vectors and hand-written sequences add targeted checks.

module tb_uart_tx_arbiter;

    localparam int BC    = 16;
    localparam int NREQ  = 4;
    localparam int FRAME = 10 * BC;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        busy;
    logic [1:0]  active_id;
    logic        tx;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .CLOCK_FREQ(16),
        .BAUD(1),
        .NREQ(NREQ)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .data(data),
        .grant(grant),
        .busy(busy),
        .active_id(active_id),
        .tx(tx)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected line level at cycle t of a frame carrying byte b.
    function automatic logic exp_tx(input int t, input logic [7:0] b);
        int p;
        p = t / BC;
        if (p == 0) return 1'b0;
        else if (p <= 8) return b[p-1];
        else return 1'b1;
    endfunction

    function automatic int rr_pick(input logic [1:0] lst, input logic [3:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(int'(lst) + k) % NREQ]) return (int'(lst) + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int oh2id(input logic [3:0] g);
        for (int i = 0; i < NREQ; i++) if (g[i]) return i;
        return -1;
    endfunction

    // ---------------- reference model ----------------
    logic       m_busy;
    int         m_t;
    logic [7:0] m_byte;
    logic [1:0] m_id;
    logic [1:0] m_last;
    logic [3:0] m_grant;
    int         m_w;

    always_comb m_w = rr_pick(m_last, req);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_t     <= 0;
            m_byte  <= '0;
            m_id    <= 2'd0;
            m_last  <= 2'd3;
            m_grant <= '0;
        end else if (!m_busy || m_t == FRAME - 1) begin
            if (m_w >= 0) begin
                m_busy  <= 1'b1;
                m_t     <= 0;
                m_byte  <= data[8*m_w +: 8];
                m_id    <= m_w[1:0];
                m_last  <= m_w[1:0];
                m_grant <= 4'b0001 << m_w;
            end else begin
                m_busy  <= 1'b0;
                m_t     <= 0;
                m_grant <= '0;
            end
        end else begin
            m_t     <= m_t + 1;
            m_grant <= '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("model_cycle", {24'd0, tx, busy, grant, active_id},
                  {24'd0, (m_busy ? exp_tx(m_t, m_byte) : 1'b1), m_busy, m_grant, m_id});
        end
    end

    // ---------------- helpers ----------------
    int         g_id  [8];
    int         g_cyc [8];
    int         g_aid [8];
    logic [7:0] g_byte[8];
    int         g_cnt;
    int         g_busy_low;

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called on the negedge where the grant is visible (frame cycle 0).
    task automatic frame_check(input string nm, input logic [7:0] b);
        int bad;
        bad = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (c > 0) @(negedge clk);
            if (tx !== exp_tx(c, b) || busy !== 1'b1) bad++;
        end
        check(nm, bad, 0);
        @(negedge clk);
        check({nm, "_end"}, {busy, tx}, 2'b01);
    endtask

    // Records up to n grants and decodes each frame from mid-bit samples.
    task automatic collect_grants(input int n, input int budget);
        logic [7:0] dec;
        int         p;
        bit         done;
        g_cnt      = 0;
        g_busy_low = 0;
        done       = 1'b0;
        dec        = '0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(negedge clk);
            if (grant != 4'b0000 && g_cnt < n) begin
                g_id[g_cnt]  = oh2id(grant);
                g_cyc[g_cnt] = cyc;
                g_aid[g_cnt] = int'(active_id);
                g_cnt++;
            end
            if (g_cnt > 0) begin
                p = cyc - g_cyc[g_cnt-1];
                if (!busy) g_busy_low++;
                if (p % BC == BC / 2 && p / BC >= 1 && p / BC <= 8) dec[p/BC-1] = tx;
                if (p == FRAME - 1) begin
                    g_byte[g_cnt-1] = dec;
                    if (g_cnt == n) done = 1'b1;
                end
            end
        end
        check("collect_done", done, 1);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vt[6];

    initial begin
        int cnt;
        int exp_seq[5];

        rst  = 1'b1;
        req  = '0;
        data = '0;

        vt[0] = '{4'b0001, 32'h000000A5, 0, 8'hA5};
        vt[1] = '{4'b1111, 32'h44332211, 1, 8'h22};
        vt[2] = '{4'b0101, 32'h0077_0066, 2, 8'h77};
        vt[3] = '{4'b0011, 32'h0000_9A3C, 0, 8'h3C};
        vt[4] = '{4'b1000, 32'hE1000000, 3, 8'hE1};
        vt[5] = '{4'b1010, 32'h00005B00, 1, 8'h5B};

        repeat (2) @(negedge clk);
        check("por_state", {grant, active_id, busy, tx}, {4'b0000, 2'd0, 1'b0, 1'b1});
        rst = 1'b0;
        @(negedge clk);

        // Table vectors: one frame each from idle, checked bit by bit.
        for (int i = 0; i < 6; i++) begin
            req  = vt[i].req;
            data = vt[i].data;
            @(negedge clk);
            check("tbl_grant", grant, 4'b0001 << vt[i].exp_id);
            check("tbl_active_id", active_id, vt[i].exp_id);
            req = '0;
            frame_check("tbl_frame", vt[i].exp_byte);
        end

        // Reset asserted mid-sim with all requests high.
        req  = 4'b1111;
        data = 32'h44332211;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_async", {grant, active_id, busy, tx}, {4'b0000, 2'd0, 1'b0, 1'b1});
        @(negedge clk);
        check("rst_held", {grant, active_id, busy, tx}, {4'b0000, 2'd0, 1'b0, 1'b1});
        rst = 1'b0;

        // All requesters held: order 0,1,2,3,0, 160 cycles apart, no idle gap.
        exp_seq = '{0, 1, 2, 3, 0};
        collect_grants(5, 6 * FRAME);
        for (int i = 0; i < 5; i++) begin
            check("all_order", g_id[i], exp_seq[i]);
            check("all_byte", g_byte[i], data[8*exp_seq[i] +: 8]);
        end
        for (int i = 0; i < 4; i++) check("all_spacing", g_cyc[i+1] - g_cyc[i], FRAME);
        check("all_busy_low", g_busy_low, 0);
        req = '0;

        // Fairness between requesters 0 and 2.
        do_reset();
        req  = 4'b0101;
        data = 32'h00C3_00B4;
        collect_grants(4, 5 * FRAME);
        for (int i = 0; i < 4; i++) begin
            check("fair_order", g_id[i], (i % 2 == 0) ? 0 : 2);
            check("fair_active_id", g_aid[i], (i % 2 == 0) ? 0 : 2);
        end
        check("fair_busy_low", g_busy_low, 0);
        req = '0;

        // Withdraw: req[1] pulses during requester 0's frame and is never served.
        do_reset();
        req  = 4'b0001;
        data = 32'h0000_993C;
        @(negedge clk);
        check("wd_grant0", grant, 4'b0001);
        req = '0;
        repeat (50) @(negedge clk);
        req[1] = 1'b1;
        repeat (50) @(negedge clk);
        req[1] = 1'b0;
        cnt = 0;
        repeat (FRAME) begin
            @(negedge clk);
            if (grant != 4'b0000) cnt++;
        end
        check("wd_no_grant", cnt, 0);
        check("wd_idle", {busy, tx}, 2'b01);

        // Reset at cycle 70 of a frame, then a clean frame for requester 3.
        req  = 4'b0001;
        data = 32'h000000F0;
        @(negedge clk);
        check("rmf_grant0", grant, 4'b0001);
        req = '0;
        repeat (70) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rmf_async", {busy, tx}, 2'b01);
        @(negedge clk);
        req  = 4'b1000;
        data = 32'h5C000000;
        rst  = 1'b0;
        collect_grants(1, 3 * FRAME);
        req = '0;
        check("rmf_id", g_id[0], 3);
        check("rmf_byte", g_byte[0], 8'h5C);
        check("rmf_busy_low", g_busy_low, 0);
        @(negedge clk);
        check("rmf_end", {busy, tx}, 2'b01);

        // Random traffic checked by the reference model each cycle.
        do_reset();
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && grant[i]) begin
                    if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                    else data[8*i +: 8] = 8'($urandom);
                end else if (req[i]) begin
                    if ($urandom_range(0, 499) == 0) req[i] = 1'b0;
                    else if ($urandom_range(0, 49) == 0) data[8*i +: 8] = 8'($urandom);
                end else if ($urandom_range(0, 199) < 3) begin
                    req[i] = 1'b1;
                    data[8*i +: 8] = 8'($urandom);
                end
            end
        end
        req = '0;
        repeat (FRAME + 10) @(negedge clk);
        check("final_idle", {busy, tx}, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
